// File: rtl/component_register_responder_if.sv
// Request/response bus between a register requester and the responder.
// Single outstanding transaction, valid/ready on both directions.
interface component_register_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_error;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/component_register_responder.sv
// Word-bus responder owning a packed component register block.
// Masked writable bits are stored; the rest come from hardware.
module component_register_responder #(
  parameter int REGISTER_BITS = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter logic [REGISTER_BITS-1:0] READ_MASK   = '1,
  parameter logic [REGISTER_BITS-1:0] WRITE_MASK  =
    {REGISTER_BITS{1'b1}} << 32,
  parameter logic [REGISTER_BITS-1:0] RESET_VALUE = '0,
  localparam int NUM_WORDS =
    (REGISTER_BITS + DATA_WIDTH - 1) / DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  component_register_responder_if.slave bus,
  input  logic [REGISTER_BITS-1:0] regs_hw_in,
  output logic [REGISTER_BITS-1:0] regs_out,
  output logic [NUM_WORDS-1:0]     write_pulse
);

  localparam int PAD_BITS = NUM_WORDS * DATA_WIDTH;

  typedef logic [REGISTER_BITS-1:0] component_registers_t;
  typedef enum logic {IDLE, RESP} state_t;

  state_t               state_q, state_d;
  component_registers_t regs_q, regs_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [NUM_WORDS-1:0] wp_q, wp_d;

  logic                  accept;
  logic                  in_range;
  logic                  wr_en;
  logic [PAD_BITS-1:0]   rd_img;
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_error = err_q;
    write_pulse   = wp_q;
  end

  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign in_range = bus.req_addr < ADDR_WIDTH'(NUM_WORDS);
  assign wr_en    = accept && bus.req_write && in_range;

  assign regs_out = (regs_q & WRITE_MASK)
                  | (regs_hw_in & ~WRITE_MASK);

  // Padding beyond REGISTER_BITS reads back as zero.
  always_comb begin
    rd_img = '0;
    rd_img[REGISTER_BITS-1:0] = regs_out & READ_MASK;
    rd_word = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (bus.req_addr == ADDR_WIDTH'(w))
        rd_word = rd_img[w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    regs_d  = regs_q;
    wp_d    = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    for (int i = 0; i < REGISTER_BITS; i++) begin
      if (wr_en && WRITE_MASK[i]
          && bus.req_addr == ADDR_WIDTH'(i / DATA_WIDTH)
          && bus.req_wstrb[(i % DATA_WIDTH) / 8])
        regs_d[i] = bus.req_wdata[i % DATA_WIDTH];
    end
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (wr_en && bus.req_addr == ADDR_WIDTH'(w))
        wp_d[w] = 1'b1;
    end
    if (accept) begin
      err_d   = !in_range;
      rdata_d = (in_range && !bus.req_write) ? rd_word : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q  <= RESET_VALUE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wp_q    <= '0;
    end else begin
      regs_q  <= regs_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wp_q    <= wp_d;
    end
  end

endmodule

// File: tb/tb_component_register_responder.sv
// Randomized scoreboard bench for component_register_responder.
// Two instances share stimulus; the second narrows READ_MASK.
module tb_component_register_responder;

  localparam logic [63:0] WM  = {32'hFFFF_FFFF, 32'h0};
  localparam logic [63:0] RMB = 64'h0000FFFF_FFFFFFFF;

  typedef struct packed {
    logic        err;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] hw;
  logic [63:0] ro_a, ro_b;
  logic [1:0]  wp_a, wp_b;

  always #5 clk = ~clk;

  component_register_responder_if #(32, 4) ifa ();
  component_register_responder_if #(32, 4) ifb ();

  assign ifb.req_valid = ifa.req_valid;
  assign ifb.req_write = ifa.req_write;
  assign ifb.req_addr  = ifa.req_addr;
  assign ifb.req_wdata = ifa.req_wdata;
  assign ifb.req_wstrb = ifa.req_wstrb;
  assign ifb.rsp_ready = ifa.rsp_ready;

  component_register_responder u_a (
    .clk(clk), .reset(reset), .bus(ifa),
    .regs_hw_in(hw), .regs_out(ro_a), .write_pulse(wp_a)
  );

  component_register_responder #(.READ_MASK(RMB)) u_b (
    .clk(clk), .reset(reset), .bus(ifb),
    .regs_hw_in(hw), .regs_out(ro_b), .write_pulse(wp_b)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] st;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model_out();
    return (st & WM) | (hw & ~WM);
  endfunction

  function automatic logic [31:0] word_of(input logic [63:0] v,
                                          input int a);
    return v[a*32 +: 32];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && ifa.rsp_valid && ifa.rsp_ready) begin
      if (qa.size() == 0) begin
        chk("rsp_a_unexpected", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("rsp_a_err", ifa.rsp_error, e.err);
        chk("rsp_a_data", ifa.rsp_rdata, e.d);
      end
    end
    if (!reset && ifb.rsp_valid && ifb.rsp_ready) begin
      if (qb.size() == 0) begin
        chk("rsp_b_unexpected", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("rsp_b_err", ifb.rsp_error, e.err);
        chk("rsp_b_data", ifb.rsp_rdata, e.d);
      end
    end
  end

  task automatic xact(input bit wr, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int stall, input bit rnd_hw);
    exp_t ea, eb;
    logic [63:0] img;
    logic [31:0] w;
    logic [1:0]  ewp;
    bit acc;
    int n;
    @(posedge clk); #1;
    ifa.req_valid = 1'b1;
    ifa.req_write = wr;
    ifa.req_addr  = a;
    ifa.req_wdata = d;
    ifa.req_wstrb = s;
    ifa.rsp_ready = 1'b0;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 8) begin
      @(negedge clk);
      if (ifa.req_ready) acc = 1'b1;
      n++;
    end
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      ifa.req_valid = 1'b0;
      return;
    end
    img = model_out();
    ewp = 2'b00;
    if (a >= 4'd2) begin
      ea = '{err: 1'b1, d: 32'h0};
      eb = ea;
    end else if (wr) begin
      ea = '{err: 1'b0, d: 32'h0};
      eb = ea;
      w = word_of(st, int'(a));
      for (int b = 0; b < 4; b++)
        if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      st[a*32 +: 32] = w;
      ewp[a[0]] = 1'b1;
    end else begin
      ea = '{err: 1'b0, d: word_of(img, int'(a))};
      eb = '{err: 1'b0, d: word_of(img & RMB, int'(a))};
    end
    qa.push_back(ea);
    qb.push_back(eb);
    @(negedge clk);
    chk("rsp_valid_rise_a", ifa.rsp_valid, 1);
    chk("rsp_valid_rise_b", ifb.rsp_valid, 1);
    chk("req_ready_low", ifa.req_ready, 0);
    chk("wpulse_a", wp_a, ewp);
    chk("wpulse_b", wp_b, ewp);
    chk("regs_out_a", ro_a, model_out());
    chk("regs_out_b", ro_b, model_out());
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      if (rnd_hw) hw = {$urandom, $urandom};
      @(negedge clk);
      chk("stall_valid", ifa.rsp_valid, 1);
      chk("stall_ready", ifa.req_ready, 0);
      chk("stall_wpulse", wp_a, 0);
      chk("stall_regs", ro_a, model_out());
    end
    @(posedge clk); #1;
    ifa.rsp_ready = 1'b1;
    ifa.req_valid = 1'b0;
    @(posedge clk); #1;
    ifa.rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready", ifa.req_ready, 1);
    chk("idle_valid", ifa.rsp_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    hw    = '0;
    st    = '0;
    ifa.req_valid = 1'b0;
    ifa.req_write = 1'b0;
    ifa.req_addr  = '0;
    ifa.req_wdata = '0;
    ifa.req_wstrb = '0;
    ifa.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rst_regs", ro_a, 0);
    chk("rst_ready", ifa.req_ready, 1);
    chk("rst_valid", ifa.rsp_valid, 0);
    chk("rst_wpulse", wp_a, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    xact(1'b1, 4'd1, 32'hABCD1234, 4'hF, 0, 1'b0);
    chk("wr1_upper", ro_a[63:32], 32'hABCD1234);
    xact(1'b0, 4'd1, 32'h0, 4'h0, 1, 1'b0);
    xact(1'b1, 4'd1, 32'h00005500, 4'b0010, 0, 1'b0);
    chk("wr2_upper", ro_a[63:32], 32'hABCD5534);
    xact(1'b0, 4'd1, 32'h0, 4'h0, 0, 1'b0);
    hw = 64'h00000000_00012345;
    xact(1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    chk("hw_lower", ro_a[31:0], 32'h00012345);
    xact(1'b0, 4'd0, 32'h0, 4'h0, 0, 1'b0);
    xact(1'b0, 4'd2, 32'h0, 4'h0, 5, 1'b0);
    xact(1'b1, 4'd1, 32'h00000000, 4'h0, 0, 1'b0);
    xact(1'b1, 4'd1, 32'hABCD1234, 4'hF, 0, 1'b0);
    chk("rmask_regs_b", ro_b[63:32], 32'hABCD1234);
    xact(1'b0, 4'd1, 32'h0, 4'h0, 2, 1'b0);

    hw = '0;
    @(posedge clk); #1;
    ifa.req_valid = 1'b1;
    ifa.req_write = 1'b0;
    ifa.req_addr  = 4'd1;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", ifa.rsp_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid_a", ifa.rsp_valid, 0);
    chk("mid_rst_valid_b", ifb.rsp_valid, 0);
    chk("mid_rst_regs", ro_a, 0);
    st = '0;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int t = 0; t < 60; t++) begin
      logic [3:0] a;
      if ($urandom_range(0, 5) == 0) a = 4'($urandom_range(2, 15));
      else                           a = 4'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) hw = {$urandom, $urandom};
      xact(1'($urandom), a, $urandom, 4'($urandom),
           int'($urandom_range(0, 3)), 1'b1);
    end

    repeat (2) @(negedge clk);
    chk("queue_drain", 64'(qa.size() + qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
